// File: rtl/fouror_pkg.sv
// Shared definitions for the fouror self-test sequencer: state codes,
// drv/obs bit positions and the golden fouror function.
package fouror_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_CHECK  = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam int unsigned DRV_A = 0;
    localparam int unsigned DRV_B = 1;
    localparam int unsigned DRV_C = 2;
    localparam int unsigned DRV_D = 3;

    localparam int unsigned OBS_E = 0;
    localparam int unsigned OBS_F = 1;
    localparam int unsigned OBS_G = 2;

    function automatic logic [2:0] fouror_golden(input logic [3:0] v);
        logic [2:0] r;
        r        = '0;
        r[OBS_E] = v[DRV_A] | v[DRV_B];
        r[OBS_F] = v[DRV_C] | v[DRV_D];
        r[OBS_G] = v[DRV_A] | v[DRV_B] | v[DRV_C] | v[DRV_D];
        return r;
    endfunction

endpackage

// File: rtl/fouror_ref.sv
// Combinational golden model of fouror: expected e/f/g for an input vector.
module fouror_ref
    import fouror_pkg::*;
(
    input  logic [3:0] vec,
    output logic [2:0] exp
);

    assign exp = fouror_golden(vec);

endmodule

// File: rtl/fouror_sweep_ctrl.sv
// Self-test sequencer: sweeps all 16 vectors into fouror, settles, samples
// e/f/g against the golden model and records pass/fail and the first error.
module fouror_sweep_ctrl
    import fouror_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] obs,
    output logic [3:0] drv,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       first_err_vld,
    output logic [3:0] first_err_vec,
    output logic [2:0] first_err_obs
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

    logic [1:0] state;
    logic [3:0] vec;
    logic [3:0] cnt;
    logic [2:0] exp_obs;

    fouror_ref u_ref (
        .vec (vec),
        .exp (exp_obs)
    );

    // drv mirrors the vector counter; both only move on sweep start and CHECK exit
    assign drv  = vec;
    assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            vec           <= '0;
            cnt           <= '0;
            pass          <= 1'b0;
            err_cnt       <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            first_err_obs <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        vec           <= '0;
                        cnt           <= '0;
                        pass          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_vld <= 1'b0;
                        first_err_vec <= '0;
                        first_err_obs <= '0;
                        state         <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (obs != exp_obs) begin
                        err_cnt <= err_cnt + 5'd1;
                        if (!first_err_vld) begin
                            first_err_vld <= 1'b1;
                            first_err_vec <= vec;
                            first_err_obs <= obs;
                        end
                    end
                    if (vec == 4'hF) begin
                        state <= ST_DONE;
                    end else begin
                        vec   <= vec + 4'd1;
                        cnt   <= '0;
                        state <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    pass  <= (err_cnt == 5'd0);
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fouror_sweep_ctrl.sv
// Directed + randomized bench for fouror_sweep_ctrl at SETTLE_CYC 2, 1 and 15,
// driving a behavioural fouror with injectable faults.
module tb_fouror_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start [3];
    logic [2:0] obs [3];
    logic [3:0] drv [3];
    logic       busy [3];
    logic       done [3];
    logic       pass [3];
    logic [4:0] err_cnt [3];
    logic       first_err_vld [3];
    logic [3:0] first_err_vec [3];
    logic [2:0] first_err_obs [3];

    int         mode;
    logic [2:0] mask [16];
    int         checks;
    int         failures;

    logic [3:0] ref_vec;
    logic [2:0] ref_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fouror_sweep_ctrl #(.SETTLE_CYC(2)) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .obs(obs[0]), .drv(drv[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err_cnt[0]),
        .first_err_vld(first_err_vld[0]), .first_err_vec(first_err_vec[0]),
        .first_err_obs(first_err_obs[0]));

    fouror_sweep_ctrl #(.SETTLE_CYC(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .obs(obs[1]), .drv(drv[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err_cnt[1]),
        .first_err_vld(first_err_vld[1]), .first_err_vec(first_err_vec[1]),
        .first_err_obs(first_err_obs[1]));

    fouror_sweep_ctrl #(.SETTLE_CYC(15)) dut2 (
        .clk(clk), .rst(rst), .start(start[2]), .obs(obs[2]), .drv(drv[2]),
        .busy(busy[2]), .done(done[2]), .pass(pass[2]), .err_cnt(err_cnt[2]),
        .first_err_vld(first_err_vld[2]), .first_err_vec(first_err_vec[2]),
        .first_err_obs(first_err_obs[2]));

    fouror_ref u_ref_chk (
        .vec (ref_vec),
        .exp (ref_exp)
    );

    // e: any of the two low inputs set, f: any of the two high, g: any at all
    function automatic logic [2:0] golden_arith(input logic [3:0] v);
        int unsigned n;
        n = v;
        return {(n != 0), (n / 4 != 0), (n % 4 != 0)};
    endfunction

    function automatic logic [2:0] apply_fault(input logic [2:0] gold, input int m,
                                               input logic [2:0] mk);
        logic [2:0] r;
        r = gold;
        case (m)
            1: r[2] = 1'b0;
            2: r[1] = 1'b1;
            3: r = gold ^ mk;
            default: ;
        endcase
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            obs[i] = apply_fault(golden_arith(drv[i]), mode, mask[drv[i]]);
        end
    end

    function automatic int settle_of(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 1 : 15;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] out_vec(input int sel);
        return {8'd0, drv[sel], busy[sel], done[sel], pass[sel], err_cnt[sel],
                first_err_vld[sel], first_err_vec[sel], first_err_obs[sel]};
    endfunction

    // One sweep on DUT sel; rst_at / restart_at are cycle offsets after the start edge (-1 = none)
    task automatic run_sweep(input int sel, input int rst_at, input int restart_at,
                             input string tag);
        int s, hold, total, c, done_c, bad_busy, bad_drv, extra;
        int         e_cnt;
        logic       e_vld;
        logic [3:0] e_vec;
        logic [2:0] e_obs;
        logic [2:0] seen;

        s     = settle_of(sel);
        hold  = s + 1;
        total = 16 * hold;
        e_cnt = 0; e_vld = 1'b0; e_vec = '0; e_obs = '0;
        for (int i = 0; i < 16; i++) begin
            seen = apply_fault(golden_arith(4'(i)), mode, mask[i]);
            if (seen != golden_arith(4'(i))) begin
                e_cnt++;
                if (!e_vld) begin
                    e_vld = 1'b1;
                    e_vec = 4'(i);
                    e_obs = seen;
                end
            end
        end

        @(posedge clk); #1 start[sel] = 1'b1;
        @(posedge clk); #1 start[sel] = 1'b0;
        c = 0; done_c = -1; bad_busy = 0; bad_drv = 0;
        while (c <= total + 4) begin
            if (c == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1 rst = 1'b0;
                chk({tag, "_rst_outputs"}, out_vec(sel), 32'd0);
                extra = 0;
                for (int k = 0; k < total + 8; k++) begin
                    if (done[sel] || busy[sel]) extra++;
                    @(posedge clk); #1;
                end
                chk({tag, "_rst_no_done"}, 32'(extra), 32'd0);
                return;
            end
            if (done[sel]) begin
                done_c = c;
                break;
            end
            if (busy[sel] !== 1'b1) bad_busy++;
            if (drv[sel] !== 4'(c / hold)) bad_drv++;
            start[sel] = (c == restart_at);
            @(posedge clk); #1;
            c++;
        end
        start[sel] = 1'b0;

        chk({tag, "_done_cycle"}, 32'(done_c), 32'(total));
        chk({tag, "_busy_during"}, 32'(bad_busy), 32'd0);
        chk({tag, "_drv_hold"}, 32'(bad_drv), 32'd0);
        chk({tag, "_busy_in_done"}, {31'd0, busy[sel]}, 32'd0);
        chk({tag, "_err_cnt"}, {27'd0, err_cnt[sel]}, 32'(e_cnt));
        chk({tag, "_first_vld"}, {31'd0, first_err_vld[sel]}, {31'd0, e_vld});
        chk({tag, "_first_vec"}, {28'd0, first_err_vec[sel]}, {28'd0, e_vec});
        chk({tag, "_first_obs"}, {29'd0, first_err_obs[sel]}, {29'd0, e_obs});

        @(posedge clk); #1;
        chk({tag, "_pass"}, {31'd0, pass[sel]}, {31'd0, (e_cnt == 0)});
        extra = 0;
        for (int k = 0; k < 4; k++) begin
            if (done[sel] || busy[sel]) extra++;
            @(posedge clk); #1;
        end
        chk({tag, "_single_done"}, 32'(extra), 32'd0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mode     = 0;
        ref_vec  = '0;
        for (int i = 0; i < 16; i++) mask[i] = '0;
        for (int i = 0; i < 3; i++) start[i] = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_dut0", out_vec(0), 32'd0);
        chk("reset_dut1", out_vec(1), 32'd0);
        chk("reset_dut2", out_vec(2), 32'd0);

        for (int i = 0; i < 16; i++) begin
            ref_vec = 4'(i);
            #1;
            chk($sformatf("ref_vec%0d", i), {29'd0, ref_exp}, {29'd0, golden_arith(4'(i))});
        end

        mode = 0; run_sweep(0, -1, -1, "clean_s2");
        mode = 1; run_sweep(0, -1, -1, "g_sa0");
        chk("g_sa0_cnt_const", {27'd0, err_cnt[0]}, 32'd15);
        chk("g_sa0_vec_const", {28'd0, first_err_vec[0]}, 32'd1);
        mode = 2; run_sweep(0, -1, -1, "f_sa1");
        chk("f_sa1_cnt_const", {27'd0, err_cnt[0]}, 32'd4);
        chk("f_sa1_obs_const", {29'd0, first_err_obs[0]}, 32'd2);
        mode = 0; run_sweep(0, -1, 10, "restart_ignored");
        mode = 1; run_sweep(0, 20, -1, "mid_reset");
        mode = 0; run_sweep(0, -1, -1, "after_reset");
        mode = 0; run_sweep(1, -1, -1, "clean_s1");
        mode = 0; run_sweep(2, -1, -1, "clean_s15");

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 16; i++) begin
                mask[i] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
            end
            mode = int'($urandom_range(0, 3));
            run_sweep(int'($urandom_range(0, 2)), -1, -1, $sformatf("rand%0d_m%0d", r, mode));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fouror_sweep_ctrl.md
# fouror_sweep_ctrl

Self-test sequencer for the `fouror` combinational block (inputs a,b,c,d; outputs e = a|b, f = c|d, g = a|b|c|d). On a start request it drives all 16 input vectors into `fouror` in order, waits a programmable settle time per vector, samples e/f/g, compares them against the golden function, and reports pass/fail, error count and first failing vector. It sits beside `fouror` on the lab board top level and replaces manual switch toggling.

## Interface
- `SETTLE_CYC`, default 2: clock cycles each vector is held before sampling; legal range 1..15.

- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  sweep request; sampled only in IDLE.
- `obs`  in  3  sampled `fouror` outputs: obs[0]=e, obs[1]=f, obs[2]=g.
- `drv`  out  4  registered vector to `fouror`: drv[0]=a, drv[1]=b, drv[2]=c, drv[3]=d.
- `busy`  out  1  high while a sweep is in progress (SETTLE or CHECK).
- `done`  out  1  one-cycle pulse when a sweep completes.
- `pass`  out  1  high when the last completed sweep had zero errors; held until the next start.
- `err_cnt`  out  5  number of mismatching vectors in the current or last sweep (0..16).
- `first_err_vld`  out  1  at least one mismatch recorded.
- `first_err_vec`  out  4  vector index of the first mismatch.
- `first_err_obs`  out  3  obs value captured at the first mismatch.

## Operation
- States: IDLE, SETTLE, CHECK, DONE.
- IDLE: drv holds its last value. On `start`=1: vec<=0, drv<=0, settle count<=0, err_cnt<=0, first_err_*<=0, pass<=0, go to SETTLE.
- SETTLE: count increments each cycle; after SETTLE_CYC cycles in SETTLE, go to CHECK.
- CHECK (1 cycle): exp = {a|b|c|d, c|d, a|b} computed from vec. If obs != exp: err_cnt+1; if first_err_vld=0, capture vec and obs and set first_err_vld. If vec==15, go to DONE; else vec<=vec+1, drv<=vec+1, count<=0, go to SETTLE.
- DONE (1 cycle): done=1, pass=(err_cnt==0), then go to IDLE.
- `start` during SETTLE, CHECK or DONE is ignored; no queuing.
- err_cnt is 5 bits, so 16 errors is representable and never wraps.
- vec is 4 bits. The 15 to 0 wrap never occurs because a sweep ends at 15.

## Timing
- Reset values: drv=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vld=0, first_err_vec=0, first_err_obs=0; state IDLE. Reset wins over every other event, including in mid-sweep. The sweep is abandoned and no `done` is issued.
- Let `start` be sampled at edge k. busy is high from k+1. Each vector occupies SETTLE_CYC+1 cycles. The last CHECK ends at edge k+16·(SETTLE_CYC+1). `done` is high for the following cycle. busy is low in DONE.
- With SETTLE_CYC=2: busy is high for 48 cycles, and done is asserted 48 cycles after the start edge.
- obs is sampled only in CHECK. drv changes only on the CHECK to SETTLE edge and on sweep start, so `fouror` sees each vector stable for SETTLE_CYC+1 cycles before sampling.
- err_cnt and first_err_* update on the edge that ends CHECK and are visible the next cycle. pass updates on entry to IDLE from DONE.

## Structure
- Shared package `fouror_pkg`: state encoding constants (IDLE/SETTLE/CHECK/DONE), bit-index constants for drv/obs, and the golden expected-output function.
- One sub-module, `fouror_ref`: a combinational golden model, vec[3:0] in, exp[2:0] out. The bench reuses it as its scoreboard.
- Everything else (FSM, settle counter, vector counter, error capture) stays in one module.

## Test plan
- Correct `fouror` connected, SETTLE_CYC=2, one start pulse: done 48 cycles after the start edge, pass=1, err_cnt=0, first_err_vld=0. drv steps 0..15, holding each value 3 cycles.
- Faulty model with g stuck-at-0: err_cnt=15, pass=0, first_err_vec=1, first_err_obs=3'b001.
- Faulty model with f stuck-at-1: errors on vectors 0..3, so err_cnt=4, first_err_vec=0, first_err_obs=3'b010.
- Second start pulse during a sweep (cycle 10): ignored. done still arrives at cycle 48 and exactly one done pulse is seen.
- rst asserted at cycle 20 of a faulty sweep: the next cycle shows all outputs at reset values and no done. A new start then completes a normal full sweep.
- SETTLE_CYC=1 and SETTLE_CYC=15: done at 32 and 256 cycles after the start edge respectively, and each drv value is held 2 and 16 cycles respectively.
